// File: rtl/tt_onboarding_pkg.sv
// Shared constants for the onboarding SPI/PWM block: register map, frame size
// and PWM period, plus the duty-to-threshold conversion.
package tt_onboarding_pkg;

  localparam int CLK_HZ     = 10_000_000;
  localparam int PWM_HZ     = 3000;
  localparam int PERIOD     = CLK_HZ / PWM_HZ;
  localparam int CNT_W      = 12;
  localparam int FRAME_BITS = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  // 255 * 3333 still fits in 20 bits, so the product never overflows.
  function automatic logic [CNT_W-1:0] duty_threshold(input logic [7:0] duty);
    logic [19:0] prod;
    prod = 20'(duty) * 20'(PERIOD);
    return prod[19:8];
  endfunction

endpackage

// File: rtl/spi_peripheral.sv
// Write-only SPI (mode 0, MSB first) slave with input synchronizers and the
// five-register configuration file.
module spi_peripheral
  import tt_onboarding_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        copi,
  input  logic        ncs,
  output logic [15:0] en_out,
  output logic [15:0] en_pwm,
  output logic [7:0]  duty
);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] copi_sync;
  logic [SYNC_STAGES-1:0] ncs_sync;
  logic                   sclk_prev;
  logic                   ncs_prev;
  logic                   frame_active;
  logic [4:0]             bit_cnt;
  logic [15:0]            shifter;

  logic sclk_s, copi_s, ncs_s;
  logic sclk_rise, ncs_fall, ncs_rise, commit;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign ncs_fall  = ~ncs_s & ncs_prev;
  assign ncs_rise  = ncs_s & ~ncs_prev;
  assign commit    = ncs_rise & frame_active & (bit_cnt == 5'(FRAME_BITS)) & shifter[15];

  // nCS chain resets low so a select held low through reset never looks like
  // a frame start; a frame needs a fresh high-to-low transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync    <= '0;
      copi_sync    <= '0;
      ncs_sync     <= '0;
      sclk_prev    <= 1'b0;
      ncs_prev     <= 1'b0;
      frame_active <= 1'b0;
      bit_cnt      <= '0;
      shifter      <= '0;
      en_out       <= '0;
      en_pwm       <= '0;
      duty         <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_prev <= sclk_s;
      ncs_prev  <= ncs_s;

      if (ncs_fall) begin
        frame_active <= 1'b1;
        bit_cnt      <= '0;
        shifter      <= '0;
      end else if (ncs_rise) begin
        frame_active <= 1'b0;
      end else if (frame_active && sclk_rise) begin
        shifter <= {shifter[14:0], copi_s};
        if (bit_cnt != '1) bit_cnt <= bit_cnt + 5'd1;
      end

      if (commit) begin
        case (shifter[14:8])
          ADDR_EN_OUT_LO: en_out[7:0]  <= shifter[7:0];
          ADDR_EN_OUT_HI: en_out[15:8] <= shifter[7:0];
          ADDR_EN_PWM_LO: en_pwm[7:0]  <= shifter[7:0];
          ADDR_EN_PWM_HI: en_pwm[15:8] <= shifter[7:0];
          ADDR_DUTY:      duty         <= shifter[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/tt_um_uwasic_onboarding_william_kim.sv
// Tiny Tapeout top: SPI register file driving 16 static/PWM output channels.
// Define PWM_GLITCHLESS_EN to apply duty writes only at the period boundary.
module tt_um_uwasic_onboarding_william_kim
  import tt_onboarding_pkg::*;
(
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [15:0]      en_out;
  logic [15:0]      en_pwm;
  logic [7:0]       duty;
  logic [7:0]       duty_act;
  logic [CNT_W-1:0] cnt;
  logic             cnt_wrap;
  logic             pwm;
  logic [15:0]      out_q;
  logic             unused;

  assign unused = &{ena, uio_in, ui_in[7:3]};

  spi_peripheral #(.SYNC_STAGES(2)) u_spi (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk   (ui_in[0]),
    .copi   (ui_in[1]),
    .ncs    (ui_in[2]),
    .en_out (en_out),
    .en_pwm (en_pwm),
    .duty   (duty)
  );

  assign cnt_wrap = (cnt == CNT_MAX);

`ifdef PWM_GLITCHLESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        duty_act <= '0;
    else if (cnt_wrap) duty_act <= duty;
  end
`else
  assign duty_act = duty;
`endif

  assign pwm = (duty_act == 8'hFF) | (cnt < duty_threshold(duty_act));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      out_q <= '0;
    end else begin
      cnt   <= cnt_wrap ? '0 : cnt + CNT_W'(1);
      out_q <= en_out & (~en_pwm | {16{pwm}});
    end
  end

  assign uo_out  = out_q[7:0];
  assign uio_out = out_q[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_uwasic_onboarding_william_kim.sv
// Scoreboard bench: SPI frames update a behavioural register/PWM model whose
// predicted pin state is queued and compared by an independent monitor.
`timescale 1ns/1ps
module tb_tt_um_uwasic_onboarding_william_kim;

  localparam int P = 3333;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] ui_in, uio_in;
  wire  [7:0] uo_out, uio_out, uio_oe;

  assign ui_in  = {5'b0, ncs, copi, sclk};
  assign uio_in = 8'h00;

  tt_um_uwasic_onboarding_william_kim dut (
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe),
    .ena     (ena),
    .clk     (clk),
    .rst_n   (rst_n)
  );

  always #50 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] eo;
    logic [15:0] ep;
    logic [7:0]  dt;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [15:0] m_en_out = '0, m_en_pwm = '0;
  logic [7:0]  m_duty = '0, act_duty = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] pins_m(logic [15:0] eo, logic [15:0] ep, logic [7:0] d, int c);
    bit p;
    p = (d == 8'hFF) || (c < (int'(d) * P) / 256);
    return eo & (~ep | {16{p}});
  endfunction

  always @(posedge clk) if (rst_n) cyc++;

  // Monitor: compare once the queued prediction is due; pin at this negedge
  // reflects counter value (cyc-1) mod P.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] d;
    if (rst_n && sb.size() > 0 && cyc >= sb[0].due) begin
      e = sb.pop_front();
`ifdef PWM_GLITCHLESS_EN
      d = act_duty;
`else
      d = e.dt;
`endif
      check("scoreboard_pins", {16'h0, uio_out, uo_out}, {16'h0, pins_m(e.eo, e.ep, d, (cyc - 1) % P)});
    end
    if (cyc > 0 && cyc % P == 0) act_duty = m_duty;
  end

  task automatic spi_frame(input logic [16:0] bits, input int nb);
    repeat (4) @(negedge clk);
    ncs = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = nb - 1; i >= 0; i--) begin
      copi = bits[i];
      repeat (5) @(negedge clk);
      sclk = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (5) @(negedge clk);
    ncs = 1'b1;
    if (nb == 16 && bits[15]) begin
      case (bits[14:8])
        7'h00: m_en_out[7:0]  = bits[7:0];
        7'h01: m_en_out[15:8] = bits[7:0];
        7'h02: m_en_pwm[7:0]  = bits[7:0];
        7'h03: m_en_pwm[15:8] = bits[7:0];
        7'h04: m_duty         = bits[7:0];
        default: ;
      endcase
    end
    sb.push_back('{m_en_out, m_en_pwm, m_duty, cyc + 8});
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    spi_frame({1'b0, 1'b1, a, d}, 16);
  endtask

  task automatic measure(output int hi, output int per, output bit ok);
    int t = 0;
    ok = 1'b1;
    while (uo_out[0] !== 1'b0 && t < 8000) begin @(negedge clk); t++; end
    while (uo_out[0] !== 1'b1 && t < 8000) begin @(negedge clk); t++; end
    if (t >= 8000) ok = 1'b0;
    hi = 0;
    while (uo_out[0] === 1'b1 && hi < 8000) begin @(negedge clk); hi++; end
    per = hi;
    while (uo_out[0] === 1'b0 && per < 8000) begin @(negedge clk); per++; end
  endtask

  task automatic count_level(input int n, input logic lvl, output int hits);
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uo_out[0] === lvl) hits++;
    end
  endtask

  initial begin
    int hi, per, hits, nb, t;
    bit ok;
    logic [15:0] fr;
    logic [6:0] a;

    repeat (3) @(negedge clk);
    check("reset_uo", {24'h0, uo_out}, 32'h00);
    check("reset_uio", {24'h0, uio_out}, 32'h00);
    check("reset_oe", {24'h0, uio_oe}, 32'hFF);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_uo", {24'h0, uo_out}, 32'h00);
    check("idle_uio", {24'h0, uio_out}, 32'h00);

    wr(7'h00, 8'hF0);
    wr(7'h01, 8'hCC);
    repeat (4) @(negedge clk);
    check("static_uo_4clk", {24'h0, uo_out}, 32'hF0);
    check("static_uio_4clk", {24'h0, uio_out}, 32'hCC);

    wr(7'h30, 8'hAA);
    spi_frame({1'b0, 16'h00FF}, 16);
    spi_frame(17'h0407F, 15);
    spi_frame(17'h180FF, 17);
    spi_frame(17'h181FF, 17);
    repeat (10) @(negedge clk);
    check("reject_uo", {24'h0, uo_out}, 32'hF0);
    check("reject_uio", {24'h0, uio_out}, 32'hCC);

    wr(7'h00, 8'h01); wr(7'h01, 8'h00);
    wr(7'h02, 8'h01); wr(7'h03, 8'h00);
    wr(7'h04, 8'h80);
    measure(hi, per, ok);
    check("pwm50_edges", {31'h0, ok}, 32'h1);
    check("pwm50_high", hi, 1666);
    check("pwm50_period", per, P);

    wr(7'h04, 8'h00);
    repeat (10) @(negedge clk);
    count_level(3 * P, 1'b1, hits);
    check("duty00_no_high", hits, 0);
    wr(7'h04, 8'hFF);
    repeat (10) @(negedge clk);
    count_level(3 * P, 1'b0, hits);
    check("dutyFF_no_low", hits, 0);

    wr(7'h00, 8'h00);
    wr(7'h04, 8'h80);
    repeat (10) @(negedge clk);
    count_level(P, 1'b1, hits);
    check("pwm_without_en_out", hits, 0);
    wr(7'h00, 8'h01);

    wr(7'h04, 8'h40);
    measure(hi, per, ok);
    measure(hi, per, ok);
    check("duty40_high", hi, 833);
    repeat (1000) @(negedge clk);
    wr(7'h04, 8'hC0);
    repeat (10) @(negedge clk);
`ifdef PWM_GLITCHLESS_EN
    check("duty_change_deferred", {31'h0, uo_out[0]}, 32'h0);
`else
    check("duty_change_immediate", {31'h0, uo_out[0]}, 32'h1);
`endif
    measure(hi, per, ok);
    check("dutyC0_edges", {31'h0, ok}, 32'h1);
    check("dutyC0_high", hi, 2499);
    check("dutyC0_period", per, P);

    for (int r = 0; r < 40; r++) begin
      a  = ($urandom % 5 == 0) ? 7'(8'h30 + $urandom % 16) : 7'($urandom % 6);
      fr = {($urandom % 4 != 0) ? 1'b1 : 1'b0, a, 8'($urandom)};
      case ($urandom % 5)
        0: nb = 15;
        1: nb = 17;
        default: nb = 16;
      endcase
      if (nb == 15)      spi_frame({2'b0, fr[15:1]}, 15);
      else if (nb == 17) spi_frame({1'($urandom), fr}, 17);
      else               spi_frame({1'b0, fr}, 16);
    end

    t = 0;
    while (sb.size() > 0 && t < 100) begin @(negedge clk); t++; end
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
